prefetch_unit: RTL
==================

PREFETCH_UNIT -- requirements
Module: prefetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 16, meaning queue entries (power of two, at least 4).
REQ-002 SHALL have parameter RESET_PC, default 16'h0200, meaning first fetch address after reset.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port mem_req  output  1  byte read request.
REQ-006 SHALL have port mem_addr  output  16  read address, valid while mem_req=1.
REQ-007 SHALL have port mem_gnt  input  1  request accepted this cycle.
REQ-008 SHALL have port mem_rvalid  input  1  read data valid, exactly one cycle after mem_gnt.
REQ-009 SHALL have port mem_rdata  input  8  read data.
REQ-010 SHALL have port q_byte0 / q_byte1 / q_byte2  output  8 each  bytes at head, head+1 and head+2 (opcode and operands).
REQ-011 SHALL have port q_count  output  $clog2(DEPTH)+1  number of valid queued bytes.
REQ-012 SHALL have port head_pc  output  16  address of q_byte0.
REQ-013 SHALL have port dec_pop  input  1  decoder consumes one instruction.
REQ-014 SHALL have port dec_len  input  2  instruction length to consume (1..3).
REQ-015 SHALL have port redirect  input  1  branch/jump taken: flush queue and refetch.
REQ-016 SHALL have port redirect_pc  input  16  new fetch address.
REQ-017 SHALL have port pop_err  output  1  one-cycle pulse on an illegal pop.

Function
REQ-018 SHALL run FSM IDLE -> REQ (mem_req=1) -> WAIT (one response outstanding) -> IDLE or REQ, plus a DROP state.
REQ-019 SHALL enter REQ only when q_count + outstanding < DEPTH; otherwise it SHALL remain in IDLE.
REQ-020 SHALL hold mem_req and mem_addr stable in REQ until mem_gnt=1, then go to WAIT.
REQ-021 SHALL, in WAIT, on mem_rvalid write mem_rdata at the tail, advance the tail mod DEPTH, increment fetch_pc mod 2^16, and go to REQ if space remains, else to IDLE.
REQ-022 SHALL, on dec_pop with dec_len in 1..q_count, advance the head by dec_len mod DEPTH and head_pc by dec_len mod 2^16.
REQ-023 SHALL ignore a pop with dec_len=0 or dec_len>q_count, leave state unchanged and pulse pop_err.
REQ-024 SHALL, on a push and a pop in the same cycle, set q_count to q_count+1-dec_len.
REQ-025 SHALL drive q_byteN combinationally from storage at (head+N) mod DEPTH; bytes at index >= q_count are don't-care.
REQ-026 SHALL, on redirect, set q_count=0, head_pc=redirect_pc and fetch_pc=redirect_pc, and discard any same-cycle pop or push.
REQ-027 SHALL, on redirect in WAIT (or in REQ with mem_gnt=1), enter DROP and discard the next mem_rvalid byte, then go to REQ.
REQ-028 SHALL, on redirect in REQ without mem_gnt, drop mem_req for one cycle (go to IDLE); any request after that SHALL use the new address.
REQ-029 SHALL, on redirect in DROP, keep the new redirect_pc and stay in DROP until the pending byte returns.
REQ-030 SHALL ignore mem_rvalid outside WAIT/DROP.

Reset
REQ-031 SHALL, on reset, set mem_req=0, q_count=0, head/tail=0, head_pc=fetch_pc=RESET_PC, pop_err=0, state=IDLE.
REQ-032 SHALL, on reset mid-transaction, not enqueue the outstanding response.

Structure
REQ-033 SHALL place the FSM state enum, RESET_PC and the length encoding in shared package v6502_pkg.
REQ-034 SHALL implement storage and pointers in one sub-module, byte_queue (push, pop-by-N, flush, 3-byte peek); the FSM and PC logic SHALL live in prefetch_unit.

Verification
REQ-035 Reset, then memory returns bytes A9,05,8D -> mem_addr sequence 0200,0201,0202; q_byte0..2=A9,05,8D; q_count=3; head_pc=0200.
REQ-036 Fill 16 bytes with no pops -> mem_req stays 0 at q_count=16; one pop of dec_len=2 -> the next request is issued the following cycle.
REQ-037 Pop dec_len=3 with q_count=2 -> pop_err pulses once; q_count remains 2; head_pc unchanged.
REQ-038 Redirect to 8000 in WAIT -> the returning byte is dropped; the next mem_addr=8000; q_count=0; head_pc=8000.
REQ-039 Simultaneous push and pop dec_len=1 at q_count=5 -> q_count stays 5; head_pc+1; tail+1.
REQ-040 Head at index 14, pop dec_len=3 -> head wraps to index 1; head_pc at FFFE wraps to 0001.

Source files
------------

// File: rtl/v6502_pkg.sv
// v6502_pkg: types shared by the instruction prefetch front end.
// FSM states, reset fetch address and instruction length encoding.
package v6502_pkg;

  localparam logic [15:0] V6502_RESET_PC = 16'h0200;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DROP = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    LEN_NONE = 2'd0,
    LEN_1    = 2'd1,
    LEN_2    = 2'd2,
    LEN_3    = 2'd3
  } ins_len_e;

  function automatic logic len_fits(
    input logic [1:0] len,
    input logic [7:0] avail
  );
    return (len != LEN_NONE) &&
           ({6'b0, len} <= avail);
  endfunction

endpackage

// File: rtl/byte_queue.sv
// byte_queue: circular byte store with push, pop-by-N and flush.
// Exposes the three bytes at the head for opcode/operand peeking.
module byte_queue #(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [7:0]              push_data,
  input  logic                    pop,
  input  logic [1:0]              pop_len,
  output logic [7:0]              peek0,
  output logic [7:0]              peek1,
  output logic [7:0]              peek2,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [CW-1:0] pop_amt;

  assign pop_amt = pop ? CW'(pop_len) : '0;

  // pointers and occupancy; a flush empties the queue
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + AW'(1);
      if (pop)
        head <= head + AW'(pop_len);
      count <= count + CW'(push) - pop_amt;
    end
  end

  // byte storage, written at the tail
  always_ff @(posedge clk) begin
    if (push && !flush && !reset)
      mem[tail] <= push_data;
  end

  assign peek0 = mem[head];
  assign peek1 = mem[head + AW'(1)];
  assign peek2 = mem[head + AW'(2)];

endmodule

// File: rtl/prefetch_unit.sv
// prefetch_unit: byte-wide instruction fetch into a small queue.
// One read outstanding at a time; redirects flush and refetch.
module prefetch_unit
  import v6502_pkg::*;
#(
  parameter int          DEPTH    = 16,
  parameter logic [15:0] RESET_PC = V6502_RESET_PC
) (
  input  logic                    clk,
  input  logic                    reset,
  output logic                    mem_req,
  output logic [15:0]             mem_addr,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [7:0]              mem_rdata,
  output logic [7:0]              q_byte0,
  output logic [7:0]              q_byte1,
  output logic [7:0]              q_byte2,
  output logic [$clog2(DEPTH):0]  q_count,
  output logic [15:0]             head_pc,
  input  logic                    dec_pop,
  input  logic [1:0]              dec_len,
  input  logic                    redirect,
  input  logic [15:0]             redirect_pc,
  output logic                    pop_err
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_state_e  state;
  logic [15:0]   fetch_pc;
  logic          pop_fits;
  logic          pop_go;
  logic          push_go;
  logic          space;
  logic [CW-1:0] pop_amt;
  logic [CW-1:0] cnt_next;

  assign pop_fits = len_fits(dec_len, 8'(q_count));
  assign pop_go   = dec_pop && pop_fits && !redirect;
  assign push_go  = (state == S_WAIT) && mem_rvalid &&
                    !redirect;
  assign pop_amt  = pop_go ? CW'(dec_len) : '0;
  assign cnt_next = q_count + CW'(push_go) - pop_amt;
  assign space    = cnt_next < FULL;
  assign mem_addr = fetch_pc;

  byte_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push_go),
    .push_data (mem_rdata),
    .pop       (pop_go),
    .pop_len   (dec_len),
    .peek0     (q_byte0),
    .peek1     (q_byte1),
    .peek2     (q_byte2),
    .count     (q_count)
  );

  // fetch sequencer, PC tracking and pop error pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      mem_req  <= 1'b0;
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      pop_err  <= 1'b0;
    end else begin
      pop_err <= dec_pop && !redirect && !pop_fits;
      if (redirect) begin
        head_pc  <= redirect_pc;
        fetch_pc <= redirect_pc;
      end else begin
        if (pop_go)
          head_pc <= head_pc + 16'(dec_len);
        if (push_go)
          fetch_pc <= fetch_pc + 16'd1;
      end
      unique case (state)
        S_IDLE: begin
          if (redirect || space) begin
            state   <= S_REQ;
            mem_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (redirect) begin
            state   <= mem_gnt ? S_DROP : S_IDLE;
            mem_req <= 1'b0;
          end else if (mem_gnt) begin
            state   <= S_WAIT;
            mem_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (redirect && !mem_rvalid) begin
            state <= S_DROP;
          end else if (mem_rvalid) begin
            if (redirect || space) begin
              state   <= S_REQ;
              mem_req <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_DROP: begin
          if (mem_rvalid) begin
            state   <= S_REQ;
            mem_req <= 1'b1;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
